// File: rtl/vga_game_window.sv
// vga_game_window: 640x480@60 raster timing, centred (optionally upscaled)
// game window mapping, and the colour/sync output stage for pacman_game.
// Optional build macro: VGA_BORDER_EN draws a 1-pixel blue ring around the
// game window. When it is undefined, no border logic exists.
module vga_game_window #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned GAME_W     = 224,
  parameter int unsigned GAME_H     = 288,
  parameter int unsigned SCALE      = 1,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic                        vga_pix_clk,
  input  logic                        rst,
  output logic [$clog2(GAME_W)-1:0]   sx,
  output logic [$clog2(GAME_H)-1:0]   sy,
  output logic                        game_pix_stb,
  output logic                        frame_stb,
  output logic                        display_enabled,
  input  logic [3:0]                  R_in,
  input  logic [3:0]                  G_in,
  input  logic [3:0]                  B_in,
  output logic [3:0]                  vga_r,
  output logic [3:0]                  vga_g,
  output logic [3:0]                  vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);
  localparam int unsigned SX_W    = $clog2(GAME_W);
  localparam int unsigned SY_W    = $clog2(GAME_H);
  localparam int unsigned SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned WIN_W   = GAME_W * SCALE;
  localparam int unsigned WIN_H   = GAME_H * SCALE;
  localparam int unsigned GAME_X0 = (H_VISIBLE - WIN_W) / 2;
  localparam int unsigned GAME_Y0 = (V_VISIBLE - WIN_H) / 2;
  localparam int unsigned SR_W    = PIPE_DELAY + 2;

  localparam logic [HC_W-1:0]  H_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0]  X_START    = HC_W'(GAME_X0);
  localparam logic [HC_W-1:0]  X_END      = HC_W'(GAME_X0 + WIN_W);
  localparam logic [VC_W-1:0]  Y_START    = VC_W'(GAME_Y0);
  localparam logic [VC_W-1:0]  Y_END      = VC_W'(GAME_Y0 + WIN_H);
  localparam logic [HC_W-1:0]  HS_START   = HC_W'(H_VISIBLE + H_FRONT);
  localparam logic [HC_W-1:0]  HS_END     = HC_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0]  VS_START   = VC_W'(V_VISIBLE + V_FRONT);
  localparam logic [VC_W-1:0]  VS_END     = VC_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [SUB_W-1:0] SCALE_LAST = SUB_W'(SCALE - 1);

  // Reject geometries where the window does not fit or the pipe is empty.
  if (SCALE < 1 || WIN_W > H_VISIBLE || WIN_H > V_VISIBLE || PIPE_DELAY < 1)
  begin : g_bad_cfg
    $error("vga_game_window: invalid SCALE/window/PIPE_DELAY configuration");
  end

  // Raster counters and line-rate game-row tracking.
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [VC_W-1:0]  vc_q, vc_d;
  logic [SUB_W-1:0] vsub_q, vsub_d;
  logic [SY_W-1:0]  gy_q, gy_d;

  // Registered game-side outputs (one cycle after the counter value).
  logic [SUB_W-1:0] hsub_q, hsub_d;
  logic [SX_W-1:0]  sx_q, sx_d;
  logic [SY_W-1:0]  sy_q, sy_d;
  logic             stb_q, stb_d;
  logic             frame_q, frame_d;
  logic             de_q, de_d;

  // Output alignment pipes and colour registers.
  logic [SR_W-1:0]       hs_sr_q, hs_sr_d;
  logic [SR_W-1:0]       vs_sr_q, vs_sr_d;
  logic [PIPE_DELAY-1:0] win_sr_q, win_sr_d;
  logic [3:0]            r_q, r_d;
  logic [3:0]            g_q, g_d;
  logic [3:0]            b_q, b_d;

  logic win_c;
  logic hs_c;
  logic vs_c;

  assign win_c = (hc_q >= X_START) && (hc_q < X_END) &&
                 (vc_q >= Y_START) && (vc_q < Y_END);
  assign hs_c  = !((hc_q >= HS_START) && (hc_q < HS_END));
  assign vs_c  = !((vc_q >= VS_START) && (vc_q < VS_END));

`ifdef VGA_BORDER_EN
  localparam logic [HC_W-1:0] H_VIS_L = HC_W'(H_VISIBLE);
  localparam logic [VC_W-1:0] V_VIS_L = VC_W'(V_VISIBLE);

  logic                  bord_q, bord_d;
  logic [PIPE_DELAY-1:0] bord_sr_q, bord_sr_d;
  logic                  ring_c;

  // One-pixel ring just outside the window, clipped to the visible area.
  assign ring_c = !win_c &&
                  (({1'b0, hc_q} + (HC_W + 1)'(1)) >= {1'b0, X_START}) &&
                  (hc_q <= X_END) &&
                  (({1'b0, vc_q} + (VC_W + 1)'(1)) >= {1'b0, Y_START}) &&
                  (vc_q <= Y_END) &&
                  (hc_q < H_VIS_L) && (vc_q < V_VIS_L);

  // Border flag follows the exact same delay as the window flag.
  always_comb begin
    bord_d       = ring_c;
    bord_sr_d    = bord_sr_q;
    bord_sr_d[0] = bord_q;
    for (int i = 1; i < int'(PIPE_DELAY); i++) begin
      bord_sr_d[i] = bord_sr_q[i-1];
    end
  end

  // Border flag registers.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      bord_q    <= 1'b0;
      bord_sr_q <= '0;
    end else begin
      bord_q    <= bord_d;
      bord_sr_q <= bord_sr_d;
    end
  end
`endif

  // Next raster position; game row advances once per SCALE lines.
  always_comb begin
    hc_d   = hc_q + HC_W'(1);
    vc_d   = vc_q;
    vsub_d = vsub_q;
    gy_d   = gy_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + VC_W'(1);
      if (vc_d == Y_START) begin
        vsub_d = '0;
        gy_d   = '0;
      end else if ((vc_d > Y_START) && (vc_d < Y_END)) begin
        if (vsub_q == SCALE_LAST) begin
          vsub_d = '0;
          gy_d   = gy_q + SY_W'(1);
        end else begin
          vsub_d = vsub_q + SUB_W'(1);
        end
      end else begin
        vsub_d = '0;
        gy_d   = '0;
      end
    end
  end

  // Game coordinates and strobes for the current raster position.
  always_comb begin
    hsub_d  = '0;
    sx_d    = '0;
    sy_d    = '0;
    stb_d   = 1'b0;
    de_d    = win_c;
    frame_d = (hc_q == '0) && (vc_q == '0);
    if (win_c) begin
      if (!de_q) begin
        hsub_d = '0;
        sx_d   = '0;
      end else if (hsub_q == SCALE_LAST) begin
        hsub_d = '0;
        sx_d   = sx_q + SX_W'(1);
      end else begin
        hsub_d = hsub_q + SUB_W'(1);
        sx_d   = sx_q;
      end
      sy_d  = gy_q;
      stb_d = (hsub_d == '0) && (vsub_q == '0);
    end
  end

  // Sync/window delay lines and the gated, registered colour.
  always_comb begin
    hs_sr_d     = {hs_sr_q[SR_W-2:0], hs_c};
    vs_sr_d     = {vs_sr_q[SR_W-2:0], vs_c};
    win_sr_d    = win_sr_q;
    win_sr_d[0] = de_q;
    for (int i = 1; i < int'(PIPE_DELAY); i++) begin
      win_sr_d[i] = win_sr_q[i-1];
    end
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (win_sr_q[PIPE_DELAY-1]) begin
      r_d = R_in;
      g_d = G_in;
      b_d = B_in;
    end
`ifdef VGA_BORDER_EN
    else if (bord_sr_q[PIPE_DELAY-1]) begin
      b_d = 4'hF;
    end
`endif
  end

  // State registers; pipes flush to inactive sync and closed window.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hc_q     <= '0;
      vc_q     <= '0;
      vsub_q   <= '0;
      gy_q     <= '0;
      hsub_q   <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      stb_q    <= 1'b0;
      frame_q  <= 1'b0;
      de_q     <= 1'b0;
      hs_sr_q  <= '1;
      vs_sr_q  <= '1;
      win_sr_q <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      vsub_q   <= vsub_d;
      gy_q     <= gy_d;
      hsub_q   <= hsub_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      stb_q    <= stb_d;
      frame_q  <= frame_d;
      de_q     <= de_d;
      hs_sr_q  <= hs_sr_d;
      vs_sr_q  <= vs_sr_d;
      win_sr_q <= win_sr_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign sx              = sx_q;
  assign sy              = sy_q;
  assign game_pix_stb    = stb_q;
  assign frame_stb       = frame_q;
  assign display_enabled = de_q;
  assign vga_r           = r_q;
  assign vga_g           = g_q;
  assign vga_b           = b_q;
  assign vga_hs          = hs_sr_q[SR_W-1];
  assign vga_vs          = vs_sr_q[SR_W-1];

endmodule

// File: tb/tb_vga_game_window.sv
// Directed bench for vga_game_window: a default 640x480 instance and a
// miniature SCALE=2 instance (28x17 raster, 6x4 game) that fits whole frames
// into a short run.
module tb_vga_game_window;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-geometry instance.
  logic [7:0] b_sx;
  logic [8:0] b_sy;
  logic       b_stb, b_frame, b_de, b_hs, b_vs;
  logic [3:0] b_r, b_g, b_b;
  logic [3:0] b_in = 4'hF;

  // Miniature instance.
  logic [2:0] s_sx;
  logic [1:0] s_sy;
  logic       s_stb, s_frame, s_de, s_hs, s_vs;
  logic [3:0] s_r, s_g, s_b;
  logic [3:0] s_rin = 4'h0;
  logic [3:0] s_gin = 4'hF;
  logic [3:0] s_bin = 4'h0;

  vga_game_window u_big (
    .vga_pix_clk(clk), .rst(rst),
    .sx(b_sx), .sy(b_sy), .game_pix_stb(b_stb), .frame_stb(b_frame),
    .display_enabled(b_de),
    .R_in(b_in), .G_in(b_in), .B_in(b_in),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hs(b_hs), .vga_vs(b_vs)
  );

  vga_game_window #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .GAME_W(6), .GAME_H(4), .SCALE(2), .PIPE_DELAY(1)
  ) u_small (
    .vga_pix_clk(clk), .rst(rst),
    .sx(s_sx), .sy(s_sy), .game_pix_stb(s_stb), .frame_stb(s_frame),
    .display_enabled(s_de),
    .R_in(s_rin), .G_in(s_gin), .B_in(s_bin),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs)
  );

  // Game stand-in with one cycle of latency: colour = registered coordinates.
  always @(posedge clk) begin
    s_rin <= {1'b0, s_sx};
    s_bin <= {2'b00, s_sy};
  end

  // Non-reset edges since the last reset.
  int k = 0;
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference models (raster position p, counted from frame start) ----
  function automatic bit big_win(int p);
    int hc = p % 800;
    int vc = (p / 800) % 525;
    return (hc >= 208) && (hc < 432) && (vc >= 96) && (vc < 384);
  endfunction

  function automatic bit big_hs(int p);
    int hc = p % 800;
    return !((hc >= 656) && (hc < 752));
  endfunction

  function automatic bit big_vs(int p);
    int vc = (p / 800) % 525;
    return !((vc >= 490) && (vc < 492));
  endfunction

  function automatic bit sm_win(int p);
    int f = p % 476;
    int hc = f % 28;
    int vc = f / 28;
    return (hc >= 4) && (hc < 16) && (vc >= 2) && (vc < 10);
  endfunction

  function automatic int sm_sx(int p);
    int f = p % 476;
    return sm_win(p) ? ((f % 28) - 4) / 2 : 0;
  endfunction

  function automatic int sm_sy(int p);
    int f = p % 476;
    return sm_win(p) ? ((f / 28) - 2) / 2 : 0;
  endfunction

  function automatic bit sm_stb(int p);
    int f = p % 476;
    return sm_win(p) && ((((f % 28) - 4) % 2) == 0) && ((((f / 28) - 2) % 2) == 0);
  endfunction

  function automatic bit sm_ring(int p);
    int f = p % 476;
    int hc = f % 28;
    int vc = f / 28;
    return !sm_win(p) && (hc >= 3) && (hc <= 16) && (vc >= 1) && (vc <= 10) &&
           (hc < 20) && (vc < 12);
  endfunction

  function automatic bit sm_hs(int p);
    int hc = (p % 476) % 28;
    return !((hc >= 22) && (hc < 25));
  endfunction

  function automatic bit sm_vs(int p);
    int vc = (p % 476) / 28;
    return !((vc >= 13) && (vc < 15));
  endfunction

  // ---- tests ----
  task automatic test_reset();
    logic [29:0] got;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (700) tick();
    n_cmp++;
    if (b_hs !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_reset_hs: got %b want 0 (k=%0d)", b_hs, k);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      got = {b_sx, b_sy, b_stb, b_frame, b_de, b_r, b_g, b_b, b_hs, b_vs};
      n_cmp++;
      if (got !== {8'd0, 9'd0, 3'b000, 12'h000, 2'b11}) begin
        n_bad++;
        $display("FAIL reset_outputs cyc%0d: got %h want %h", i, got,
                 {8'd0, 9'd0, 3'b000, 12'h000, 2'b11});
      end
      n_cmp++;
      if ({s_hs, s_vs, s_de, s_frame} !== 4'b1100) begin
        n_bad++;
        $display("FAIL reset_small cyc%0d: got %b want 1100", i, {s_hs, s_vs, s_de, s_frame});
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({b_frame, s_frame, b_hs, b_de} !== 4'b1110) begin
      n_bad++;
      $display("FAIL frame_after_release: got %b want 1110", {b_frame, s_frame, b_hs, b_de});
    end
    tick();
    n_cmp++;
    if ({b_frame, s_frame} !== 2'b00) begin
      n_bad++;
      $display("FAIL frame_one_cycle: got %b want 00", {b_frame, s_frame});
    end
  endtask

  task automatic test_small_sync();
    int hs_lows = 0;
    for (int i = 0; i < 2 * 476; i++) begin
      bit ehs, evs;
      tick();
      ehs = (k >= 3) ? sm_hs(k - 3) : 1'b1;
      evs = (k >= 3) ? sm_vs(k - 3) : 1'b1;
      if (!s_hs) hs_lows++;
      n_cmp++;
      if ({s_hs, s_vs} !== {ehs, evs}) begin
        n_bad++;
        $display("FAIL small_sync k=%0d: got %b want %b", k, {s_hs, s_vs}, {ehs, evs});
      end
      n_cmp++;
      if (s_frame !== (((k - 1) % 476) == 0)) begin
        n_bad++;
        $display("FAIL small_frame_stb k=%0d: got %b", k, s_frame);
      end
    end
    n_cmp++;
    if (hs_lows != 2 * 17 * 3) begin
      n_bad++;
      $display("FAIL small_hs_low_count: got %0d want %0d", hs_lows, 2 * 17 * 3);
    end
  endtask

  task automatic test_scale2();
    int stb_cnt = 0;
    for (int i = 0; i < 476; i++) begin
      int p;
      tick();
      p = k - 1;
      if (s_stb) stb_cnt++;
      n_cmp++;
      if ({s_de, s_stb, s_sx, s_sy} !==
          {sm_win(p), sm_stb(p), 3'(sm_sx(p)), 2'(sm_sy(p))}) begin
        n_bad++;
        $display("FAIL scale2_map k=%0d: got de%b stb%b sx%0d sy%0d want de%b stb%b sx%0d sy%0d",
                 k, s_de, s_stb, s_sx, s_sy, sm_win(p), sm_stb(p), sm_sx(p), sm_sy(p));
      end
    end
    n_cmp++;
    if (stb_cnt != 24) begin
      n_bad++;
      $display("FAIL scale2_stb_count: got %0d want 24", stb_cnt);
    end
  endtask

  task automatic test_colour_border();
    int blue = 0;
    int want_blue;
    for (int i = 0; i < 476; i++) begin
      int q;
      logic [11:0] exp_rgb;
      tick();
      q = k - 3;
      exp_rgb = 12'h000;
      if (sm_win(q))
        exp_rgb = {4'(sm_sx(q)), 4'hF, 4'(sm_sy(q))};
`ifdef VGA_BORDER_EN
      else if (sm_ring(q))
        exp_rgb = 12'h00F;
`endif
      if ({s_r, s_g, s_b} === 12'h00F) blue++;
      n_cmp++;
      if ({s_r, s_g, s_b} !== exp_rgb) begin
        n_bad++;
        $display("FAIL small_colour k=%0d: got %h want %h", k, {s_r, s_g, s_b}, exp_rgb);
      end
    end
`ifdef VGA_BORDER_EN
    want_blue = 44;
`else
    want_blue = 0;
`endif
    n_cmp++;
    if (blue != want_blue) begin
      n_bad++;
      $display("FAIL blue_only_count: got %0d want %0d", blue, want_blue);
    end
  endtask

  task automatic test_big_sync();
    for (int i = 0; i < 1600; i++) begin
      tick();
      n_cmp++;
      if ({b_hs, b_vs, b_frame} !== {big_hs(k - 3), big_vs(k - 3), 1'b0}) begin
        n_bad++;
        $display("FAIL big_sync k=%0d: got %b want %b", k, {b_hs, b_vs, b_frame},
                 {big_hs(k - 3), big_vs(k - 3), 1'b0});
      end
    end
  endtask

  task automatic test_line96();
    int run = 0;
    int best = 0;
    int f_cnt = 0;
    while (k < 77008) tick();
    for (int i = 0; i < 232; i++) begin
      int p, q, hc;
      tick();
      p = k - 1;
      q = k - 3;
      hc = p % 800;
      if (b_de) begin
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      if (b_r === 4'hF) f_cnt++;
      n_cmp++;
      if ({b_de, b_stb, b_sx, b_sy} !==
          {big_win(p), big_win(p), (big_win(p) ? 8'(hc - 208) : 8'd0), 9'd0}) begin
        n_bad++;
        $display("FAIL line96_map k=%0d: got de%b stb%b sx%0d sy%0d want de%b sx%0d",
                 k, b_de, b_stb, b_sx, b_sy, big_win(p), big_win(p) ? hc - 208 : 0);
      end
      n_cmp++;
      if ({b_r, b_g, b_b} !== (big_win(q) ? 12'hFFF : 12'h000)) begin
        n_bad++;
        $display("FAIL line96_colour k=%0d: got %h want %h", k, {b_r, b_g, b_b},
                 big_win(q) ? 12'hFFF : 12'h000);
      end
    end
    n_cmp++;
    if (best != 224) begin
      n_bad++;
      $display("FAIL line96_de_run: got %0d want 224", best);
    end
    n_cmp++;
    if (f_cnt != 224) begin
      n_bad++;
      $display("FAIL line96_colour_count: got %0d want 224", f_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_small_sync();
    test_scale2();
    test_colour_border();
    test_big_sync();
    test_line96();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
